burst_mem_ctrl: RTL and testbench
=================================

Name: burst_mem_ctrl

Overview:
Burst-mode physical memory controller directly downstream of the CPU top's memory port, which the cacheline adaptor drives.
- Accepts line-aligned 256-bit read/write transactions as four 64-bit beats.
- Backs them with an internal line-organised storage array after a programmable access latency.
- Used as the synthesizable memory model for system benches and FPGA bring-up.

Parameters:
LINE_IDX_BITS, 8, number of line-index bits; storage holds 2**LINE_IDX_BITS 32-byte lines.
READ_LATENCY, 10, cycles from request acceptance to first read beat; legal range 1-255.
WRITE_LATENCY, 10, cycles from request acceptance to first write beat; legal range 1-255.

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
mem_read  input  1  read request, held high by requester until its last beat
mem_write  input  1  write request, held high by requester until its last beat
mem_address  input  32  byte address; bits [4:0] ignored
mem_wdata  input  64  write beat, must be valid in every cycle mem_resp=1 during a write
mem_resp  output  1  beat strobe, high for exactly 4 consecutive cycles per transaction
mem_rdata  output  64  read beat, valid when mem_resp=1
protocol_err  output  1  sticky error flag, cleared only by reset

Behaviour:
- Reset (reset_n=0 at edge): state IDLE, mem_resp=0, mem_rdata=0, protocol_err=0, beat counter 0, latency counter 0. Storage contents are NOT cleared.
- Reset mid-transaction: abandon it immediately. Any beats already written remain in storage.
- States: IDLE, WAIT, BURST, DONE.
- IDLE: at an edge where mem_read|mem_write=1, latch the operation and line index mem_address[4+LINE_IDX_BITS:5]. Load latency counter with LAT-1, LAT = READ_LATENCY or WRITE_LATENCY. Go to WAIT.
- Timing: acceptance edge ends cycle T; first mem_resp=1 in cycle T+LAT.
- WAIT: decrement counter; at zero go to BURST with beat counter 0.
- BURST: all outputs registered.
  - mem_resp=1 for beats k=0..3.
  - Read: mem_rdata = line[64k+63:64k].
  - Write: at the edge ending beat k, mem_wdata is written into line[64k+63:64k].
  - After beat 3, go to DONE.
- DONE: one turnaround cycle, mem_resp=0, then IDLE. Requests are not sampled in DONE. The requester must have dropped its request by then.
- mem_rdata=0 whenever mem_resp=0.
- Latched address/operation are held; mem_address changes after acceptance are ignored.
- Address wrap: bits above the line index are ignored. Line index L+2**LINE_IDX_BITS aliases line L.
- mem_read and mem_write both high at acceptance: perform a read and set protocol_err.
- Request deasserted during WAIT or BURST: complete the transaction anyway and set protocol_err.
- Write then read of the same line: the read returns the new data. The write completes before IDLE is re-entered, so there is no hazard.

Optional Feature:
Macro BMC_RANDOM_LATENCY_EN.
- Defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seeded 16'hACE1 at reset, advances once per accepted request.
  - Effective LAT = base latency + lfsr[3:0], so latency ranges over base..base+15.
- Undefined: LFSR absent and latency is fixed at the parameter value.
- Beat spacing, DONE turnaround and error rules are identical in both builds.

Decomposition:
- Package burst_mem_pkg:
  - constants BEATS=4, BEAT_W=64, LINE_W=256, OFFSET_BITS=5;
  - enum bmc_state_t {IDLE, WAIT, BURST, DONE};
  - LFSR_SEED constant.
- Sub-module bmc_lfsr: 16-bit LFSR with clk, reset_n, advance and value[15:0]. Instantiated only under BMC_RANDOM_LATENCY_EN.
- Storage is an inferred array inside burst_mem_ctrl, written per 64-bit beat.

Test Plan:
- Reset, then write line 0x40 with beats 0x1111..,0x2222..,0x3333..,0x4444.. and read 0x40 back. Required: mem_resp first high exactly 10 cycles after each acceptance, 4 beats returned in order, data matches.
- Back-to-back reads of 0x00 and 0x20 with requests re-raised the cycle after DONE. Required: exactly one idle DONE cycle between bursts, no extra mem_resp pulses.
- Write 0xA5A5.. pattern to 0x0000_0100, read 0x0000_2100 (LINE_IDX_BITS=8). Required: aliased data returned, protocol_err=0.
- mem_read=mem_write=1 at 0x80. Required: read performed, storage unchanged, protocol_err=1 until reset.
- Assert reset_n=0 during beat 2 of a write. Required: next cycle mem_resp=0 and state IDLE. A subsequent read shows beats 0-1 new and beats 2-3 old.
- With BMC_RANDOM_LATENCY_EN, 100 random reads. Required: every latency within [10,25], latency sequence reproducible across runs from seed 0xACE1.

Source files
------------

// File: rtl/burst_mem_pkg.sv
// Shared constants and state encoding for the burst memory controller.
// Used by burst_mem_ctrl and bmc_lfsr.
package burst_mem_pkg;

   localparam int BEATS       = 4;
   localparam int BEAT_W      = 64;
   localparam int LINE_W      = 256;
   localparam int OFFSET_BITS = 5;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      BURST,
      DONE
   } bmc_state_t;

endpackage

// File: rtl/bmc_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to jitter the access latency.
// Only instantiated when BMC_RANDOM_LATENCY_EN is defined.
module bmc_lfsr
   import burst_mem_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        advance,
   output logic [15:0] value
);

   always_ff @(posedge clk) begin
      if (!reset_n)
         value <= LFSR_SEED;
      else if (advance)
         value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
   end

endmodule

// File: rtl/burst_mem_ctrl.sv
// Burst-mode memory model: 256-bit lines moved as four 64-bit beats after a fixed
// access latency. Define BMC_RANDOM_LATENCY_EN to add 0..15 cycles of LFSR jitter.
module burst_mem_ctrl
   import burst_mem_pkg::*;
#(
   parameter int LINE_IDX_BITS = 8,
   parameter int READ_LATENCY  = 10,
   parameter int WRITE_LATENCY = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_address,
   input  logic [63:0] mem_wdata,
   output logic        mem_resp,
   output logic [63:0] mem_rdata,
   output logic        protocol_err
);

   localparam int LINES = 2 ** LINE_IDX_BITS;

   bmc_state_t               state, next_state;
   logic [8:0]               lat_cnt, lat_cnt_d;
   logic [1:0]               beat, beat_d;
   logic                     op_write, op_write_d;
   logic [LINE_IDX_BITS-1:0] line, line_d;
   logic                     resp_d;
   logic [BEAT_W-1:0]        rdata_d;
   logic                     err_d;

   logic                     req;
   logic [8:0]               base_lat;
   logic [8:0]               eff_lat;

   logic [BEAT_W-1:0]        storage [0:LINES*BEATS-1];

   assign req      = mem_read | mem_write;
   assign base_lat = mem_read ? 9'(READ_LATENCY) : 9'(WRITE_LATENCY);

`ifdef BMC_RANDOM_LATENCY_EN
   logic [15:0] lfsr_value;
   logic        unused_lfsr_bits;

   bmc_lfsr u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .advance (state == IDLE && req),
      .value   (lfsr_value)
   );

   assign eff_lat          = base_lat + {5'd0, lfsr_value[3:0]};
   assign unused_lfsr_bits = ^lfsr_value[15:4];
`else
   assign eff_lat = base_lat;
`endif

   logic unused_addr_bits;
   assign unused_addr_bits = ^{mem_address[31:OFFSET_BITS+LINE_IDX_BITS],
                               mem_address[OFFSET_BITS-1:0]};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         lat_cnt      <= '0;
         beat         <= '0;
         op_write     <= 1'b0;
         line         <= '0;
         mem_resp     <= 1'b0;
         mem_rdata    <= '0;
         protocol_err <= 1'b0;
      end else begin
         state        <= next_state;
         lat_cnt      <= lat_cnt_d;
         beat         <= beat_d;
         op_write     <= op_write_d;
         line         <= line_d;
         mem_resp     <= resp_d;
         mem_rdata    <= rdata_d;
         protocol_err <= err_d;
      end
   end

   // A latency of 1 has no WAIT cycle at all; otherwise leave WAIT when the count reaches 1
   // so that the registered first beat lands exactly LAT cycles after acceptance.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (req) next_state = (eff_lat == 9'd1) ? BURST : WAIT;
         WAIT:    if (lat_cnt == 9'd1) next_state = BURST;
         BURST:   if (beat == 2'd3) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      lat_cnt_d  = lat_cnt;
      beat_d     = beat;
      op_write_d = op_write;
      line_d     = line;
      err_d      = protocol_err;
      resp_d     = 1'b0;
      rdata_d    = '0;
      case (state)
         IDLE: begin
            beat_d = 2'd0;
            if (req) begin
               op_write_d = mem_write & ~mem_read;
               line_d     = mem_address[OFFSET_BITS +: LINE_IDX_BITS];
               lat_cnt_d  = eff_lat - 9'd1;
               if (mem_read && mem_write) err_d = 1'b1;
            end
         end
         WAIT: begin
            lat_cnt_d = lat_cnt - 9'd1;
            beat_d    = 2'd0;
            if (!req) err_d = 1'b1;
         end
         BURST: begin
            beat_d = beat + 2'd1;
            if (!req) err_d = 1'b1;
         end
         DONE:    beat_d = 2'd0;
         default: beat_d = 2'd0;
      endcase
      if (next_state == BURST) begin
         resp_d = 1'b1;
         if (!op_write_d) rdata_d = storage[{line_d, beat_d}];
      end
   end

   // Storage survives reset; a beat whose closing edge sees reset is not written.
   always_ff @(posedge clk) begin
      if (reset_n && state == BURST && op_write)
         storage[{line, beat}] <= mem_wdata;
   end

endmodule

// File: tb/tb_burst_mem_ctrl.sv
// Directed self-checking bench for burst_mem_ctrl (latency, beats, aliasing,
// error flag, reset mid-burst; LFSR latency sequence when BMC_RANDOM_LATENCY_EN).
module tb_burst_mem_ctrl;
   import burst_mem_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [31:0] mem_address = '0;
   logic [63:0] mem_wdata = '0;
   wire         mem_resp;
   wire  [63:0] mem_rdata;
   wire         protocol_err;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] lfsr_model;
   logic [63:0] rd_beats [4];
   int          lat;
   int          beats_seen;
   logic        done_resp;
   logic [63:0] done_rdata;

   burst_mem_ctrl dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_wdata    (mem_wdata),
      .mem_resp     (mem_resp),
      .mem_rdata    (mem_rdata),
      .protocol_err (protocol_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int model_lat();
`ifdef BMC_RANDOM_LATENCY_EN
      return 10 + int'(lfsr_model[3:0]);
`else
      return 10;
`endif
   endfunction

   task automatic advance_model;
      lfsr_model = {lfsr_model[14:0],
                    lfsr_model[15] ^ lfsr_model[13] ^ lfsr_model[12] ^ lfsr_model[10]};
   endtask

   task automatic apply_reset;
      reset_n   = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      tick;
      tick;
      reset_n    = 1'b1;
      lfsr_model = 16'hACE1;
   endtask

   // Runs one full transaction starting from the cycle after DONE; records what was seen.
   task automatic do_xfer(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [63:0] w0, input logic [63:0] w1,
                          input logic [63:0] w2, input logic [63:0] w3,
                          output int exp_lat);
      logic [63:0] wd [4];
      wd[0] = w0; wd[1] = w1; wd[2] = w2; wd[3] = w3;
      tick;
      mem_read    = rd;
      mem_write   = wr;
      mem_address = addr;
      exp_lat     = model_lat();
      tick;
      advance_model;
      mem_address = 32'hDEAD_BEEF;
      lat = 1;
      while (mem_resp !== 1'b1 && lat < 300) begin
         tick;
         lat++;
      end
      beats_seen = 0;
      for (int k = 0; k < 4; k++) begin
         mem_wdata   = wd[k];
         rd_beats[k] = mem_rdata;
         if (mem_resp === 1'b1) beats_seen++;
         tick;
      end
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_wdata  = '0;
      done_resp  = mem_resp;
      done_rdata = mem_rdata;
   endtask

   task automatic test_reset;
      apply_reset;
      vectors++;
      if (mem_resp !== 1'b0) begin
         miscompares++; $display("[TB] FAIL reset_resp: got %b, expected 0", mem_resp);
      end
      vectors++;
      if (mem_rdata !== 64'd0) begin
         miscompares++; $display("[TB] FAIL reset_rdata: got %h, expected 0", mem_rdata);
      end
      vectors++;
      if (protocol_err !== 1'b0) begin
         miscompares++; $display("[TB] FAIL reset_err: got %b, expected 0", protocol_err);
      end
      vectors++;
      if (dut.state !== IDLE) begin
         miscompares++; $display("[TB] FAIL reset_state: got %0d, expected IDLE", dut.state);
      end
   endtask

   task automatic test_write_read;
      int e;
      logic [63:0] exp [4];
      exp[0] = 64'h1111_1111_1111_1111; exp[1] = 64'h2222_2222_2222_2222;
      exp[2] = 64'h3333_3333_3333_3333; exp[3] = 64'h4444_4444_4444_4444;
      do_xfer(1'b0, 1'b1, 32'h40, exp[0], exp[1], exp[2], exp[3], e);
      vectors++;
      if (lat !== e) begin
         miscompares++; $display("[TB] FAIL wr_latency: got %0d, expected %0d", lat, e);
      end
      vectors++;
      if (beats_seen !== 4 || done_resp !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL wr_beats: got %0d beats done_resp=%b, expected 4 beats done_resp=0", beats_seen, done_resp);
      end
      do_xfer(1'b1, 1'b0, 32'h40, '0, '0, '0, '0, e);
      vectors++;
      if (lat !== e) begin
         miscompares++; $display("[TB] FAIL rd_latency: got %0d, expected %0d", lat, e);
      end
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (rd_beats[k] !== exp[k]) begin
            miscompares++; $display("[TB] FAIL rd_beat%0d: got %h, expected %h", k, rd_beats[k], exp[k]);
         end
      end
      vectors++;
      if (done_resp !== 1'b0 || done_rdata !== 64'd0) begin
         miscompares++;
         $display("[TB] FAIL rd_done: got resp=%b rdata=%h, expected resp=0 rdata=0", done_resp, done_rdata);
      end
      vectors++;
      if (protocol_err !== 1'b0) begin
         miscompares++; $display("[TB] FAIL wr_rd_err: got %b, expected 0", protocol_err);
      end
   endtask

   task automatic test_back_to_back;
      int e;
      logic [63:0] a [4];
      logic [63:0] b [4];
      for (int k = 0; k < 4; k++) begin
         a[k] = 64'hA000_0000_0000_0000 + 64'(k);
         b[k] = 64'hB000_0000_0000_0000 + 64'(k);
      end
      do_xfer(1'b0, 1'b1, 32'h00, a[0], a[1], a[2], a[3], e);
      do_xfer(1'b0, 1'b1, 32'h20, b[0], b[1], b[2], b[3], e);
      do_xfer(1'b1, 1'b0, 32'h00, '0, '0, '0, '0, e);
      vectors++;
      if (lat !== e || beats_seen !== 4 || done_resp !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL b2b_first: got lat=%0d beats=%0d done=%b, expected lat=%0d beats=4 done=0", lat, beats_seen, done_resp, e);
      end
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (rd_beats[k] !== a[k]) begin
            miscompares++; $display("[TB] FAIL b2b_a%0d: got %h, expected %h", k, rd_beats[k], a[k]);
         end
      end
      do_xfer(1'b1, 1'b0, 32'h20, '0, '0, '0, '0, e);
      vectors++;
      if (lat !== e || beats_seen !== 4 || done_resp !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL b2b_second: got lat=%0d beats=%0d done=%b, expected lat=%0d beats=4 done=0", lat, beats_seen, done_resp, e);
      end
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (rd_beats[k] !== b[k]) begin
            miscompares++; $display("[TB] FAIL b2b_b%0d: got %h, expected %h", k, rd_beats[k], b[k]);
         end
      end
   endtask

   task automatic test_alias;
      int e;
      logic [63:0] p [4];
      p[0] = 64'hA5A5_A5A5_A5A5_A5A5; p[1] = 64'h5A5A_5A5A_5A5A_5A5A;
      p[2] = 64'hA5A5_A5A5_0000_0000; p[3] = 64'h0000_0000_A5A5_A5A5;
      do_xfer(1'b0, 1'b1, 32'h0000_0100, p[0], p[1], p[2], p[3], e);
      do_xfer(1'b1, 1'b0, 32'h0000_2100, '0, '0, '0, '0, e);
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (rd_beats[k] !== p[k]) begin
            miscompares++; $display("[TB] FAIL alias_beat%0d: got %h, expected %h", k, rd_beats[k], p[k]);
         end
      end
      vectors++;
      if (protocol_err !== 1'b0) begin
         miscompares++; $display("[TB] FAIL alias_err: got %b, expected 0", protocol_err);
      end
   endtask

   task automatic test_both_high;
      int e;
      logic [63:0] p [4];
      for (int k = 0; k < 4; k++) p[k] = 64'h0123_4567_89AB_CD00 + 64'(k);
      do_xfer(1'b0, 1'b1, 32'h80, p[0], p[1], p[2], p[3], e);
      do_xfer(1'b1, 1'b1, 32'h80, 64'hFFFF_0000_0000_0000, 64'hFFFF_0000_0000_0001,
              64'hFFFF_0000_0000_0002, 64'hFFFF_0000_0000_0003, e);
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (rd_beats[k] !== p[k]) begin
            miscompares++; $display("[TB] FAIL both_rd%0d: got %h, expected %h", k, rd_beats[k], p[k]);
         end
      end
      vectors++;
      if (protocol_err !== 1'b1) begin
         miscompares++; $display("[TB] FAIL both_err_set: got %b, expected 1", protocol_err);
      end
      do_xfer(1'b1, 1'b0, 32'h80, '0, '0, '0, '0, e);
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (rd_beats[k] !== p[k]) begin
            miscompares++; $display("[TB] FAIL both_unchanged%0d: got %h, expected %h", k, rd_beats[k], p[k]);
         end
      end
      vectors++;
      if (protocol_err !== 1'b1) begin
         miscompares++; $display("[TB] FAIL both_err_sticky: got %b, expected 1", protocol_err);
      end
      apply_reset;
      vectors++;
      if (protocol_err !== 1'b0) begin
         miscompares++; $display("[TB] FAIL both_err_cleared: got %b, expected 0", protocol_err);
      end
   endtask

   task automatic test_reset_mid_write;
      int e;
      int wait_cnt;
      logic [63:0] o [4];
      logic [63:0] n [4];
      logic [63:0] exp [4];
      for (int k = 0; k < 4; k++) begin
         o[k] = 64'h0DD0_0000_0000_0000 + 64'(k);
         n[k] = 64'h0E0E_0000_0000_0000 + 64'(k);
      end
      do_xfer(1'b0, 1'b1, 32'hC0, o[0], o[1], o[2], o[3], e);
      tick;
      mem_write   = 1'b1;
      mem_address = 32'hC0;
      tick;
      advance_model;
      wait_cnt = 1;
      while (mem_resp !== 1'b1 && wait_cnt < 300) begin
         tick;
         wait_cnt++;
      end
      mem_wdata = n[0];
      tick;
      mem_wdata = n[1];
      tick;
      vectors++;
      if (mem_resp !== 1'b1) begin
         miscompares++; $display("[TB] FAIL midrst_beat2_resp: got %b, expected 1", mem_resp);
      end
      mem_wdata = n[2];
      reset_n   = 1'b0;
      tick;
      vectors++;
      if (mem_resp !== 1'b0) begin
         miscompares++; $display("[TB] FAIL midrst_resp: got %b, expected 0", mem_resp);
      end
      vectors++;
      if (dut.state !== IDLE) begin
         miscompares++; $display("[TB] FAIL midrst_state: got %0d, expected IDLE", dut.state);
      end
      reset_n    = 1'b1;
      mem_write  = 1'b0;
      mem_wdata  = '0;
      lfsr_model = 16'hACE1;
      do_xfer(1'b1, 1'b0, 32'hC0, '0, '0, '0, '0, e);
      exp[0] = n[0]; exp[1] = n[1]; exp[2] = o[2]; exp[3] = o[3];
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (rd_beats[k] !== exp[k]) begin
            miscompares++; $display("[TB] FAIL midrst_rd%0d: got %h, expected %h", k, rd_beats[k], exp[k]);
         end
      end
   endtask

`ifdef BMC_RANDOM_LATENCY_EN
   task automatic test_random_latency;
      int e;
      apply_reset;
      for (int i = 0; i < 100; i++) begin
         do_xfer(1'b1, 1'b0, 32'(i) << 5, '0, '0, '0, '0, e);
         vectors++;
         if (lat !== e || lat < 10 || lat > 25) begin
            miscompares++; $display("[TB] FAIL rand_lat%0d: got %0d, expected %0d", i, lat, e);
         end
      end
   endtask
`endif

   initial begin
      lfsr_model = 16'hACE1;
      test_reset;
      test_write_read;
      test_back_to_back;
      test_alias;
      test_both_high;
      test_reset_mid_write;
`ifdef BMC_RANDOM_LATENCY_EN
      test_random_latency;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
